fpdiv_mant_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one iterative mantissa divider (24-bit restoring, `div_mantissa`) among NREQ requesters.
- Accepts operand pairs over valid/ready handshakes and launches the divider.
- Waits for the divider's done pulse and returns the quotient to the granted requester with a held response handshake.
- Bypasses the divider on a zero divisor.
- Sits between the FP divide front-ends (per-lane unpack units) and the single shared divider instance.

---
 rtl/fpdiv_mant_arbiter_if.sv | 36 +++
 rtl/fpdiv_mant_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fpdiv_mant_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpdiv_mant_arbiter_if.sv
// Handshake bundle between the FP divide lane front-ends, the mantissa arbiter and the shared divider.
interface fpdiv_mant_arbiter_if #(
  parameter int DATAWIDTH = 24,
  parameter int NREQ      = 2
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*DATAWIDTH-1:0] req_dividend;
  logic [NREQ*DATAWIDTH-1:0] req_divisor;
  logic [NREQ-1:0]           resp_valid;
  logic [NREQ-1:0]           resp_ready;
  logic [DATAWIDTH-1:0]      resp_quotient;
  logic                      resp_dz;
  logic                      resp_err;
  logic                      busy;
  logic                      div_en;
  logic [2:0]                div_mode;
  logic [DATAWIDTH-1:0]      div_dividend;
  logic [DATAWIDTH-1:0]      div_divisor;
  logic                      div_isdone;
  logic [DATAWIDTH-1:0]      div_quotient;

  // arbiter view
  modport slave (
    input  req_valid, req_dividend, req_divisor, resp_ready, div_isdone, div_quotient,
    output req_ready, resp_valid, resp_quotient, resp_dz, resp_err, busy,
           div_en, div_mode, div_dividend, div_divisor
  );

  // requester + divider view
  modport master (
    output req_valid, req_dividend, req_divisor, resp_ready, div_isdone, div_quotient,
    input  req_ready, resp_valid, resp_quotient, resp_dz, resp_err, busy,
           div_en, div_mode, div_dividend, div_divisor
  );
endinterface

// File: rtl/fpdiv_mant_arbiter.sv
// Round-robin sharing of one iterative mantissa divider among NREQ lanes, with zero-divisor bypass.
// Optional divider watchdog enabled by defining FPDIV_ARB_TIMEOUT_EN.
module fpdiv_mant_arbiter #(
  parameter int DATAWIDTH = 24,
  parameter int NREQ      = 2,
  parameter int TIMEOUT   = 64
) (
  input logic                clk,
  input logic                rst,
  fpdiv_mant_arbiter_if.slave bus
);
  // state | meaning: IDLE arbitrate+accept | ISSUE pulse div_en | WAIT await done | RESP hold result
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2) begin : g_bad_param
    $error("fpdiv_mant_arbiter: unsupported parameter set");
  end

  state_t               state, state_nxt;
  logic [PW-1:0]        rr_ptr, gnt_idx, cur_idx, ptr_nxt;
  logic                 gnt_found, accept, timed_out, hold;
  logic [NREQ-1:0]      req_ready, resp_valid;
  logic [DATAWIDTH-1:0] opa, opb, quot, sel_dvd, sel_dsr;
  logic                 dz;
  logic [DATAWIDTH-1:0] dvd_arr [NREQ];
  logic [DATAWIDTH-1:0] dsr_arr [NREQ];
  logic [PW:0]          idx_w;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      dvd_arr[i] = bus.req_dividend[i*DATAWIDTH +: DATAWIDTH];
      dsr_arr[i] = bus.req_divisor[i*DATAWIDTH +: DATAWIDTH];
    end
  end

  // Scan from the highest offset down so the closest line to rr_ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx_w     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_w = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(NREQ)) idx_w = idx_w - (PW+1)'(NREQ);
      if (bus.req_valid[idx_w[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx_w[PW-1:0];
      end
    end
  end

  assign sel_dvd = dvd_arr[gnt_idx];
  assign sel_dsr = dsr_arr[gnt_idx];
  assign ptr_nxt = (cur_idx == PW'(NREQ - 1)) ? '0 : cur_idx + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    bus.div_en = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found && !hold && !rst) begin
          req_ready[gnt_idx] = 1'b1;
          accept             = 1'b1;
          state_nxt          = (sel_dsr == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        bus.div_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (bus.div_isdone || timed_out) state_nxt = RESP;
      end
      RESP: begin
        resp_valid[cur_idx] = 1'b1;
        if (bus.resp_ready[cur_idx]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FPDIV_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(2 * DATAWIDTH + 1);

  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] drain_cnt;
  logic          drain_pend;
  logic          err;

  assign timed_out = (state == WAIT) && !bus.div_isdone && (wait_cnt == CW'(TIMEOUT));
  assign hold      = drain_pend;

  // After a timeout the divider may still be running; keep it idle until it reports or has surely finished.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      drain_cnt  <= '0;
      drain_pend <= 1'b0;
    end else begin
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CW'(1);
      if (timed_out) begin
        drain_pend <= 1'b1;
        drain_cnt  <= '0;
      end else if (drain_pend) begin
        if (bus.div_isdone || drain_cnt == DW'(2 * DATAWIDTH - 1)) drain_pend <= 1'b0;
        else drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

  assign bus.resp_err = err;
`else
  assign timed_out    = 1'b0;
  assign hold         = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      quot    <= '0;
      dz      <= 1'b0;
      cur_idx <= '0;
      rr_ptr  <= '0;
`ifdef FPDIV_ARB_TIMEOUT_EN
      err     <= 1'b0;
`endif
    end else begin
      if (accept) begin
        opa     <= sel_dvd;
        opb     <= sel_dsr;
        cur_idx <= gnt_idx;
        if (sel_dsr == '0) begin
          quot <= '1;
          dz   <= 1'b1;
`ifdef FPDIV_ARB_TIMEOUT_EN
          err  <= 1'b0;
`endif
        end
      end
      if (state == WAIT && bus.div_isdone) begin
        quot <= bus.div_quotient;
        dz   <= 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
        err  <= 1'b0;
      end else if (timed_out) begin
        quot <= '0;
        dz   <= 1'b0;
        err  <= 1'b1;
`endif
      end
      if (state == RESP && bus.resp_ready[cur_idx]) rr_ptr <= ptr_nxt;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_quotient = quot;
  assign bus.resp_dz       = dz;
  assign bus.busy          = (state != IDLE);
  assign bus.div_mode      = 3'd3;
  assign bus.div_dividend  = opa;
  assign bus.div_divisor   = opb;
endmodule

// File: tb/tb_fpdiv_mant_arbiter.sv
// Directed bench for fpdiv_mant_arbiter with a behavioural 24-bit restoring divider model.
module tb_fpdiv_mant_arbiter;
  localparam int DW = 24;
  localparam int NR = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpdiv_mant_arbiter_if #(.DATAWIDTH(DW), .NREQ(NR)) bus ();
  fpdiv_mant_arbiter #(.DATAWIDTH(DW), .NREQ(NR), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Divider model: done pulse 49 cycles after the div_en cycle, quotient = (a << 23) / b.
  logic          model_done = 1'b0;
  logic          act        = 1'b0;
  logic [6:0]    rem        = 7'd0;
  logic [DW-1:0] model_q    = '0;
  logic          kill       = 1'b0;
  logic          spur       = 1'b0;
  int            en_count   = 0;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (rst) begin
      act     <= 1'b0;
      rem     <= 7'd0;
      model_q <= '0;
    end else if (bus.div_en) begin
      act      <= 1'b1;
      rem      <= 7'd48;
      model_q  <= DW'({1'b0, bus.div_dividend, 23'b0} / {24'b0, bus.div_divisor});
      en_count <= en_count + 1;
    end else if (act) begin
      if (rem == 7'd1) begin
        model_done <= 1'b1;
        act        <= 1'b0;
      end else begin
        rem <= rem - 7'd1;
      end
    end
  end

  assign bus.div_isdone   = (model_done & ~kill) | spur;
  assign bus.div_quotient = spur ? 24'hABCDEF : model_q;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (bus.resp_valid == '0 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int n, m, snap;
  logic stable;

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.resp_ready   = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_busy",       48'(bus.busy),          48'(0));
    chk("rst_resp_valid", 48'(bus.resp_valid),    48'(0));
    chk("rst_req_ready",  48'(bus.req_ready),     48'(0));
    chk("rst_div_en",     48'(bus.div_en),        48'(0));
    chk("rst_div_mode",   48'(bus.div_mode),      48'(3));
    chk("rst_quotient",   48'(bus.resp_quotient), 48'(0));
    chk("rst_flags",      48'({bus.resp_dz, bus.resp_err}), 48'(0));

    // lane 0: 1.5 / 1.0
    bus.req_dividend[23:0] = 24'hC00000;
    bus.req_divisor[23:0]  = 24'h800000;
    bus.req_valid = 2'b01;
    #1;
    chk("a_req_ready", 48'(bus.req_ready), 48'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    chk("a_div_en",  48'(bus.div_en), 48'(1));
    chk("a_div_ops", {bus.div_dividend, bus.div_divisor}, {24'hC00000, 24'h800000});
    chk("a_busy",    48'(bus.busy), 48'(1));
    wait_resp(n);
    chk("a_latency_from_t1", 48'(n), 48'(50));
    chk("a_resp_valid", 48'(bus.resp_valid),    48'(2'b01));
    chk("a_quotient",   48'(bus.resp_quotient), 48'(24'hC00000));
    chk("a_flags",      48'({bus.resp_dz, bus.resp_err}), 48'(0));

    // hold response 10 cycles; lane 1 waiting, wrong-lane ready and a stray done pulse must be ignored
    bus.req_dividend[47:24] = 24'h800000;
    bus.req_divisor[47:24]  = 24'h800000;
    bus.req_valid  = 2'b10;
    bus.resp_ready = 2'b10;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      spur = (i == 3);
      tick();
      spur = 1'b0;
      if (bus.req_ready != 2'b00 || bus.resp_valid != 2'b01 ||
          bus.resp_quotient != 24'hC00000 || bus.resp_dz != 1'b0) stable = 1'b0;
    end
    chk("hold_stable", 48'(stable), 48'(1));
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    chk("a_resp_cleared", 48'(bus.resp_valid), 48'(0));
    chk("b_req_ready",    48'(bus.req_ready),  48'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    wait_resp(n);
    chk("b_latency_from_t1", 48'(n), 48'(50));
    chk("b_resp_valid", 48'(bus.resp_valid),    48'(2'b10));
    chk("b_quotient",   48'(bus.resp_quotient), 48'(24'h800000));
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = 2'b00;

    // both lanes valid, pointer back at 0; lane 1 has a zero divisor
    bus.req_dividend = {24'h123456, 24'h400000};
    bus.req_divisor  = {24'h000000, 24'h800000};
    bus.req_valid = 2'b11;
    #1;
    chk("c_req_ready_rr0", 48'(bus.req_ready), 48'(2'b01));
    tick();
    bus.req_valid = 2'b10;
    wait_resp(n);
    chk("c_latency_from_t1", 48'(n), 48'(50));
    chk("c_resp_valid", 48'(bus.resp_valid),    48'(2'b01));
    chk("c_quotient",   48'(bus.resp_quotient), 48'(24'h400000));
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    chk("d_req_ready", 48'(bus.req_ready), 48'(2'b10));
    snap = en_count;
    tick();
    bus.req_valid = 2'b00;
    chk("d_bypass_valid", 48'(bus.resp_valid),    48'(2'b10));
    chk("d_bypass_quot",  48'(bus.resp_quotient), 48'(24'hFFFFFF));
    chk("d_bypass_dz",    48'(bus.resp_dz),       48'(1));
    chk("d_no_div_en",    48'(bus.div_en),        48'(0));
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = 2'b00;
    chk("d_resp_cleared", 48'(bus.resp_valid), 48'(0));
    tick();
    chk("d_divider_unused", 48'(en_count), 48'(snap));

    // reset in the middle of WAIT
    bus.req_dividend[23:0] = 24'h800000;
    bus.req_divisor[23:0]  = 24'hC00000;
    bus.req_valid = 2'b01;
    #1;
    chk("e_req_ready", 48'(bus.req_ready), 48'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    repeat (19) tick();
    chk("e_busy_before_rst", 48'(bus.busy), 48'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("e_busy_after_rst",  48'(bus.busy),       48'(0));
    chk("e_resp_after_rst",  48'(bus.resp_valid), 48'(0));
    bus.req_dividend[47:24] = 24'hFFFFFF;
    bus.req_divisor[47:24]  = 24'h800000;
    bus.req_valid = 2'b10;
    #1;
    chk("f_req_ready", 48'(bus.req_ready), 48'(2'b10));
    tick();
    bus.req_valid = 2'b00;
    wait_resp(n);
    chk("f_latency_from_t1", 48'(n), 48'(50));
    chk("f_resp_valid", 48'(bus.resp_valid),    48'(2'b10));
    chk("f_quotient",   48'(bus.resp_quotient), 48'(24'hFFFFFF));
    chk("f_dz",         48'(bus.resp_dz),       48'(0));
    bus.resp_ready = 2'b10;
    tick();
    bus.resp_ready = 2'b00;

`ifdef FPDIV_ARB_TIMEOUT_EN
    // divider never answers: watchdog response at t0+19, then next issue held off
    kill = 1'b1;
    bus.req_dividend[23:0] = 24'hC00000;
    bus.req_divisor[23:0]  = 24'h800000;
    bus.req_valid = 2'b01;
    #1;
    chk("g_req_ready", 48'(bus.req_ready), 48'(2'b01));
    tick();
    bus.req_valid = 2'b00;
    wait_resp(n);
    chk("g_latency_from_t1", 48'(n), 48'(18));
    chk("g_resp_valid", 48'(bus.resp_valid),    48'(2'b01));
    chk("g_err",        48'(bus.resp_err),      48'(1));
    chk("g_quotient",   48'(bus.resp_quotient), 48'(0));
    chk("g_dz",         48'(bus.resp_dz),       48'(0));
    bus.resp_ready = 2'b01;
    tick();
    bus.resp_ready = 2'b00;
    bus.req_valid = 2'b10;
    #1;
    chk("g_holdoff", 48'(bus.req_ready), 48'(0));
    m = 0;
    while (bus.req_ready == 2'b00 && m < 100) begin
      tick();
      m++;
    end
    chk("g_holdoff_released", 48'(m > 0 && m < 100), 48'(1));
    tick();
    bus.req_valid = 2'b00;
    kill = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
